// File: rtl/lsin_glitch_filter.sv
// Per-channel synchronizer and stability filter for level-shifted HV-domain inputs,
// with registered edge pulses and a maskable sticky interrupt.
module lsin_glitch_filter #(
    parameter int              WIDTH       = 4,
    parameter int              SYNC_STAGES = 2,
    parameter int              CNT_W       = 8,
    parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}}
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] filt_len_i,
    input  logic [WIDTH-1:0] irq_mask_i,
    input  logic             irq_clr_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             irq_o,
    output logic [WIDTH-1:0] dbg_state_o
);

    localparam logic [0:0] ST_STABLE = 1'b0;
    localparam logic [0:0] ST_CAND   = 1'b1;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [0:0]       state_q [WIDTH];
    logic [0:0]       state_d [WIDTH];
    logic [CNT_W-1:0] cnt_q   [WIDTH];
    logic [CNT_W-1:0] cnt_d   [WIDTH];
    logic [CNT_W:0]   cnt_inc [WIDTH];
    logic [CNT_W:0]   len_eff;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             irq_q, irq_d;

    assign s = sync_q[SYNC_STAGES-1];

    // Compare in CNT_W+1 bits so cnt+1 cannot wrap at the largest filter length.
    always_comb begin
        len_eff = (filt_len_i == '0) ? {{CNT_W{1'b0}}, 1'b1} : {1'b0, filt_len_i};
        for (int i = 0; i < WIDTH; i++) begin
            cnt_inc[i] = {1'b0, cnt_q[i]} + {{CNT_W{1'b0}}, 1'b1};
        end
    end

    always_comb begin
        dout_d = dout_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i]   = cnt_q[i];
            state_d[i] = state_q[i];
            if (!en_i || (s[i] == dout_q[i])) begin
                cnt_d[i]   = '0;
                state_d[i] = ST_STABLE;
            end else if (cnt_inc[i] < len_eff) begin
                cnt_d[i]   = cnt_inc[i][CNT_W-1:0];
                state_d[i] = ST_CAND;
            end else begin
                dout_d[i]  = s[i];
                rise_d[i]  = s[i];
                fall_d[i]  = ~s[i];
                cnt_d[i]   = '0;
                state_d[i] = ST_STABLE;
            end
        end
        // A pulse already on the outputs beats a coincident clear.
        if (|((rise_q | fall_q) & irq_mask_i)) begin
            irq_d = 1'b1;
        end else if (irq_clr_i) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= RESET_VAL;
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i]   <= '0;
                state_q[i] <= ST_STABLE;
            end
            dout_q <= RESET_VAL;
            rise_q <= '0;
            fall_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            sync_q[0] <= din_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i]   <= cnt_d[i];
                state_q[i] <= state_d[i];
            end
            dout_q <= dout_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            irq_q  <= irq_d;
        end
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            dbg_state_o[i] = state_q[i][0];
        end
    end

    assign dout_o = dout_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign irq_o  = irq_q;

endmodule

// File: tb/tb_lsin_glitch_filter.sv
// Directed bench for lsin_glitch_filter: a per-cycle vector table plus hand-written
// sequences for long filter lengths, reset mid-candidate, enable drop and length change.
module tb_lsin_glitch_filter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] din = '0;
    logic       en = 1'b0;
    logic [7:0] len = '0;
    logic [3:0] mask = '0;
    logic       clr = 1'b0;
    logic [3:0] dout, rise, fall, dbg_state;
    logic       irq;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] din;
        logic       en;
        logic [7:0] len;
        logic [3:0] mask;
        logic       clr;
        int         n;
        logic [3:0] e_dout;
        logic [3:0] e_rise;
        logic [3:0] e_fall;
        logic       e_irq;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] exp_q[$];

    lsin_glitch_filter dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .din_i       (din),
        .en_i        (en),
        .filt_len_i  (len),
        .irq_mask_i  (mask),
        .irq_clr_i   (clr),
        .dout_o      (dout),
        .rise_o      (rise),
        .fall_o      (fall),
        .irq_o       (irq),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        din = '0; en = 1'b0; len = '0; mask = '0; clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] d, input logic e, input logic [7:0] l,
                         input logic [3:0] m, input logic c);
        din = d; en = e; len = l; mask = m; clr = c;
    endtask

    task automatic add(input logic [3:0] d, input logic e, input logic [7:0] l,
                       input logic [3:0] m, input logic c, input int n,
                       input logic [3:0] ed, input logic [3:0] er,
                       input logic [3:0] ef, input logic ei);
        vec_t v;
        v.din = d; v.en = e; v.len = l; v.mask = m; v.clr = c; v.n = n;
        v.e_dout = ed; v.e_rise = er; v.e_fall = ef; v.e_irq = ei;
        tbl.push_back(v);
    endtask

    // scoreboard
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    int bad;

    initial begin
        // rows: din en len mask clr cycles | dout rise fall irq
        add(4'b0001, 1, 4, 4'b0001, 0, 5, 4'b0000, 4'b0000, 4'b0000, 0);
        add(4'b0001, 1, 4, 4'b0001, 0, 1, 4'b0001, 4'b0001, 4'b0000, 0);
        add(4'b0001, 1, 4, 4'b0001, 0, 1, 4'b0001, 4'b0000, 4'b0000, 1);
        add(4'b0001, 1, 4, 4'b0001, 0, 2, 4'b0001, 4'b0000, 4'b0000, 1);
        add(4'b0001, 1, 4, 4'b0001, 1, 1, 4'b0001, 4'b0000, 4'b0000, 0);
        add(4'b0001, 1, 4, 4'b0001, 0, 2, 4'b0001, 4'b0000, 4'b0000, 0);
        add(4'b0011, 1, 4, 4'b0001, 0, 3, 4'b0001, 4'b0000, 4'b0000, 0);
        add(4'b0001, 1, 4, 4'b0001, 0, 6, 4'b0001, 4'b0000, 4'b0000, 0);
        add(4'b0010, 1, 1, 4'b0010, 0, 2, 4'b0001, 4'b0000, 4'b0000, 0);
        add(4'b0010, 1, 1, 4'b0010, 0, 1, 4'b0010, 4'b0010, 4'b0001, 0);
        add(4'b0010, 1, 1, 4'b0010, 0, 1, 4'b0010, 4'b0000, 4'b0000, 1);
        add(4'b0000, 1, 1, 4'b0010, 0, 2, 4'b0010, 4'b0000, 4'b0000, 1);
        add(4'b0000, 1, 1, 4'b0010, 0, 1, 4'b0000, 4'b0000, 4'b0010, 1);
        add(4'b0000, 1, 1, 4'b0010, 1, 1, 4'b0000, 4'b0000, 4'b0000, 1);
        add(4'b0000, 1, 1, 4'b0010, 1, 1, 4'b0000, 4'b0000, 4'b0000, 0);
        add(4'b0000, 1, 1, 4'b0010, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0);
        add(4'b0100, 1, 0, 4'b0010, 0, 2, 4'b0000, 4'b0000, 4'b0000, 0);
        add(4'b0100, 1, 0, 4'b0010, 0, 1, 4'b0100, 4'b0100, 4'b0000, 0);
        add(4'b0100, 1, 0, 4'b0010, 0, 1, 4'b0100, 4'b0000, 4'b0000, 0);
        add(4'b0000, 0, 4, 4'b0010, 0, 8, 4'b0100, 4'b0000, 4'b0000, 0);
        add(4'b0000, 1, 4, 4'b0010, 0, 3, 4'b0100, 4'b0000, 4'b0000, 0);
        add(4'b0000, 1, 4, 4'b0010, 0, 1, 4'b0000, 4'b0000, 4'b0100, 0);
        add(4'b0000, 1, 4, 4'b0010, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0);

        // reset state
        #12;
        chk("reset_outputs", {dout, rise, fall, dbg_state}, 16'h0000);
        chk("reset_irq", {15'd0, irq}, 16'h0000);
        do_reset();

        foreach (tbl[r]) begin
            drive(tbl[r].din, tbl[r].en, tbl[r].len, tbl[r].mask, tbl[r].clr);
            for (int c = 0; c < tbl[r].n; c++) begin
                tick();
                exp_q.push_back({tbl[r].e_dout, tbl[r].e_rise, tbl[r].e_fall, 3'b000, tbl[r].e_irq});
                chk($sformatf("row%0d_cyc%0d", r, c), {dout, rise, fall, 3'b000, irq}, exp_q.pop_front());
            end
        end

        // filter length 255 on ch3: update exactly 2+255 edges after the input change
        do_reset();
        drive(4'b1000, 1, 8'd255, 4'b1000, 0);
        bad = 0;
        for (int c = 1; c <= 256; c++) begin
            tick();
            if (dout !== 4'b0000 || rise !== 4'b0000) bad++;
            if (c == 100) chk("len255_candidate", {12'd0, dbg_state}, 16'h0008);
        end
        chk("len255_early_updates", bad[15:0], 16'h0000);
        tick();
        chk("len255_update", {8'd0, dout, rise}, 16'h0088);
        tick();
        chk("len255_irq", {8'd0, rise, 3'b000, irq}, 16'h0001);

        // reset asserted with ch2 at cnt=3 of a length-8 candidate
        drive(4'b1100, 1, 8'd8, 4'b0000, 0);
        repeat (5) tick();
        chk("pre_reset_cand", {12'd0, dbg_state}, 16'h0004);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_outs", {dout, rise, fall, dbg_state}, 16'h0000);
        chk("async_reset_irq", {15'd0, irq}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (dout !== 4'b0000 || rise !== 4'b0000) bad++;
        end
        chk("post_reset_early", bad[15:0], 16'h0000);
        tick();
        chk("post_reset_update", {8'd0, dout, rise}, 16'h00cc);

        // enable drop mid-candidate restarts the count
        drive(4'b0000, 1, 8'd4, 4'b0000, 0);
        repeat (4) tick();
        chk("en_cand", {dout, 8'd0, dbg_state}, 16'hc00c);
        en = 1'b0;
        repeat (2) tick();
        chk("en_off_held", {dout, fall, 4'd0, dbg_state}, 16'hc000);
        en = 1'b1;
        repeat (3) tick();
        chk("en_on_wait", {dout, fall, 8'd0}, 16'hc000);
        tick();
        chk("en_on_update", {8'd0, dout, fall}, 16'h000c);

        // filter length shortened mid-candidate takes effect on the next edge
        drive(4'b0001, 1, 8'd8, 4'b0000, 0);
        repeat (6) tick();
        chk("len_chg_before", {dout, rise, 4'd0, dbg_state}, 16'h0001);
        len = 8'd3;
        tick();
        chk("len_chg_update", {8'd0, dout, rise}, 16'h0011);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
